// File: rtl/approx_adder_level_ctrl_if.sv
// ---------------------------------------------------------------------------
// approx_adder_level_ctrl_if
// Purpose : bundles every non-clock/reset signal of approx_adder_level_ctrl:
//           the operand request handshake, the drive/return path of the
//           external carry-select approximate adder, the result handshake,
//           the level/forcing controls and the window status.
// Modports:
//   slave  - the controller (approx_adder_level_ctrl)
//   master - the surroundings: requester, adder, consumer and config source
// Signals :
//   in_valid/in_ready, in_a[3:0], in_b[3:0], in_cin     operand request
//   adder_in1/in2[3:0], adder_cin, adder_sel[2:0]        to the adder
//   adder_sum[4:0]                                       from the adder
//   out_valid/out_ready, out_sum[4:0], out_err[4:0]      result
//   level[1:0], cfg_force, cfg_level[1:0]                level control
//   win_done, err_acc[ERR_W-1:0]                         window status
// ---------------------------------------------------------------------------
interface approx_adder_level_ctrl_if #(
    parameter int ERR_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_a;
    logic [3:0]       in_b;
    logic             in_cin;
    logic [3:0]       adder_in1;
    logic [3:0]       adder_in2;
    logic             adder_cin;
    logic [2:0]       adder_sel;
    logic [4:0]       adder_sum;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       out_sum;
    logic [4:0]       out_err;
    logic [1:0]       level;
    logic             cfg_force;
    logic [1:0]       cfg_level;
    logic             win_done;
    logic [ERR_W-1:0] err_acc;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, adder_sum, out_ready,
               cfg_force, cfg_level,
        output in_ready, adder_in1, adder_in2, adder_cin, adder_sel,
               out_valid, out_sum, out_err, level, win_done, err_acc
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, adder_sum, out_ready,
               cfg_force, cfg_level,
        input  in_ready, adder_in1, adder_in2, adder_cin, adder_sel,
               out_valid, out_sum, out_err, level, win_done, err_acc
    );
endinterface

// File: rtl/approx_adder_level_ctrl.sv
// ---------------------------------------------------------------------------
// approx_adder_level_ctrl
// Purpose : sequences operations through an external 4-bit carry-select
//           approximate adder, measures each result against the exact sum,
//           accumulates the error over a window of operations and steps the
//           approximation level down (more accurate) or up (more
//           approximate) at the end of every window.
// Ports   :
//   clk    - clock
//   rst_n  - asynchronous active-low reset
//   bus    - approx_adder_level_ctrl_if.slave (see interface header)
// Flow    : IDLE (accept, register operands + sel) -> EXEC (adder settles,
//           result and error captured) -> RESP (hold until consumer takes it,
//           then fold the error into the window accumulator).
// ---------------------------------------------------------------------------
module approx_adder_level_ctrl #(
    parameter int WINDOW     = 8,
    parameter int HI_THR     = 12,
    parameter int LO_THR     = 2,
    parameter int ERR_W      = 8,
    parameter int INIT_LEVEL = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    approx_adder_level_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0]       InitLevel = 2'(INIT_LEVEL);
    localparam logic [7:0]       WinCount  = 8'(WINDOW);
    localparam logic [ERR_W-1:0] HiThr     = ERR_W'(HI_THR);
    localparam logic [ERR_W-1:0] LoThr     = ERR_W'(LO_THR);

    // Higher level predicts more of the stage carries, starting from C[0].
    function automatic logic [2:0] level_to_sel(input logic [1:0] lvl);
        logic [2:0] sel;
        case (lvl)
            2'd0:    sel = 3'b000;
            2'd1:    sel = 3'b001;
            2'd2:    sel = 3'b011;
            default: sel = 3'b111;
        endcase
        return sel;
    endfunction

    state_t           state_q,     state_d;
    logic [3:0]       adder_in1_q, adder_in1_d;
    logic [3:0]       adder_in2_q, adder_in2_d;
    logic             adder_cin_q, adder_cin_d;
    logic [2:0]       adder_sel_q, adder_sel_d;
    logic [4:0]       exact_q,     exact_d;
    logic [4:0]       out_sum_q,   out_sum_d;
    logic [4:0]       out_err_q,   out_err_d;
    logic [1:0]       level_q,     level_d;
    logic [ERR_W-1:0] err_acc_q,   err_acc_d;
    logic [7:0]       count_q,     count_d;
    logic             win_done_q,  win_done_d;

    // Accumulator update for the op being handed over; the extra top bit
    // detects overflow so the sum can clamp at all-ones.
    logic [ERR_W:0]   acc_wide;
    logic [ERR_W-1:0] acc_sat;
    logic [7:0]       count_inc;

    assign acc_wide  = {1'b0, err_acc_q} + (ERR_W+1)'(out_err_q);
    assign acc_sat   = acc_wide[ERR_W] ? {ERR_W{1'b1}} : acc_wide[ERR_W-1:0];
    assign count_inc = count_q + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            adder_in1_q <= 4'd0;
            adder_in2_q <= 4'd0;
            adder_cin_q <= 1'b0;
            adder_sel_q <= level_to_sel(InitLevel);
            exact_q     <= 5'd0;
            out_sum_q   <= 5'd0;
            out_err_q   <= 5'd0;
            level_q     <= InitLevel;
            err_acc_q   <= '0;
            count_q     <= 8'd0;
            win_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            adder_in1_q <= adder_in1_d;
            adder_in2_q <= adder_in2_d;
            adder_cin_q <= adder_cin_d;
            adder_sel_q <= adder_sel_d;
            exact_q     <= exact_d;
            out_sum_q   <= out_sum_d;
            out_err_q   <= out_err_d;
            level_q     <= level_d;
            err_acc_q   <= err_acc_d;
            count_q     <= count_d;
            win_done_q  <= win_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        adder_in1_d = adder_in1_q;
        adder_in2_d = adder_in2_q;
        adder_cin_d = adder_cin_q;
        adder_sel_d = adder_sel_q;
        exact_d     = exact_q;
        out_sum_d   = out_sum_q;
        out_err_d   = out_err_q;
        level_d     = level_q;
        err_acc_d   = err_acc_q;
        count_d     = count_q;
        win_done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    adder_in1_d = bus.in_a;
                    adder_in2_d = bus.in_b;
                    adder_cin_d = bus.in_cin;
                    // sel is frozen here so later level changes never touch
                    // this operation.
                    adder_sel_d = level_to_sel(level_q);
                    exact_d     = {1'b0, bus.in_a} + {1'b0, bus.in_b}
                                  + {4'd0, bus.in_cin};
                    state_d     = EXEC;
                end
            end

            EXEC: begin
                out_sum_d = bus.adder_sum;
                out_err_d = (exact_q >= bus.adder_sum) ? exact_q - bus.adder_sum
                                                       : bus.adder_sum - exact_q;
                state_d   = RESP;
            end

            RESP: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    if (count_inc == WinCount) begin
                        // Thresholds see the accumulator including this op.
                        if (acc_sat > HiThr && level_q != 2'd0) begin
                            level_d = level_q - 2'd1;
                        end else if (acc_sat < LoThr && level_q != 2'd3) begin
                            level_d = level_q + 2'd1;
                        end
                        err_acc_d  = '0;
                        count_d    = 8'd0;
                        win_done_d = 1'b1;
                    end else begin
                        err_acc_d = acc_sat;
                        count_d   = count_inc;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        // Forcing overrides any window update in the same cycle but leaves the
        // operation pipeline alone.
        if (bus.cfg_force) begin
            level_d    = bus.cfg_level;
            err_acc_d  = '0;
            count_d    = 8'd0;
            win_done_d = 1'b0;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == RESP);
    assign bus.adder_in1 = adder_in1_q;
    assign bus.adder_in2 = adder_in2_q;
    assign bus.adder_cin = adder_cin_q;
    assign bus.adder_sel = adder_sel_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_err   = out_err_q;
    assign bus.level     = level_q;
    assign bus.win_done  = win_done_q;
    assign bus.err_acc   = err_acc_q;

endmodule
